// File: rtl/h264_cc_pkg.sv
// Shared types and constants for the H.264 chroma 8x8 DC intra predictor.
package h264_cc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TOPRD,
    CALC,
    DATA,
    WAITFB
  } state_t;

  localparam logic [7:0] DC_DEFAULT = 8'd128;
  localparam logic [1:0] CMODE_DC   = 2'd0;
  localparam logic [4:0] FB_FULL    = 5'd16;

  // Sum of the four unsigned bytes of a 32-bit pixel word.
  function automatic logic [9:0] byte_sum(input logic [31:0] w);
    return {2'b00, w[7:0]} + {2'b00, w[15:8]} + {2'b00, w[23:16]} + {2'b00, w[31:24]};
  endfunction

endpackage

// File: rtl/h264_cc_dcpred.sv
// DC rule for one 4x4 chroma sub-block from its top and left neighbour sums.
module h264_cc_dcpred
  import h264_cc_pkg::*;
(
  input  logic [9:0] t_sum,
  input  logic [9:0] l_sum,
  input  logic       top_av,
  input  logic       left_av,
  input  logic [1:0] blk,
  output logic [7:0] dc
);

  logic [9:0]  t_rnd;
  logic [9:0]  l_rnd;
  logic [10:0] b_rnd;

  assign t_rnd = t_sum + 10'd2;
  assign l_rnd = l_sum + 10'd2;
  assign b_rnd = {1'b0, t_sum} + {1'b0, l_sum} + 11'd4;

  // Off-diagonal blocks favour the neighbour they touch directly.
  always_comb begin
    dc = DC_DEFAULT;
    case (blk)
      2'd1: begin
        if (top_av)       dc = t_rnd[9:2];
        else if (left_av) dc = l_rnd[9:2];
      end
      2'd2: begin
        if (left_av)      dc = l_rnd[9:2];
        else if (top_av)  dc = t_rnd[9:2];
      end
      default: begin
        if (top_av && left_av) dc = b_rnd[10:3];
        else if (top_av)       dc = t_rnd[9:2];
        else if (left_av)      dc = l_rnd[9:2];
      end
    endcase
  end

endmodule

// File: rtl/h264_intra8x8_cc.sv
// Chroma DC intra predictor: reads top neighbours, forms per-4x4 DCs, streams
// residuals, prediction base and residual DC sums, and collects left feedback.
module h264_intra8x8_cc
  import h264_cc_pkg::*;
(
  input  logic        CLK2,
  input  logic        RSTN,
  input  logic        NEWSLICE,
  input  logic        NEWLINE,
  input  logic        STROBEI,
  input  logic [31:0] DATAI,
  input  logic [31:0] TOPI,
  input  logic        FBSTROBE,
  input  logic [7:0]  FEEDBI,
  input  logic        READYO,
  output logic        READYI,
  output logic        STROBEO,
  output logic [35:0] DATAO,
  output logic [31:0] BASEO,
  output logic        DCSTROBEO,
  output logic [15:0] DCDATAO,
  output logic [1:0]  CMODEO,
  output logic [1:0]  XXO,
  output logic        XXC,
  output logic        XXINC
);

  state_t            state_q, state_d;
  logic              ns_q, ns_d, nl_q, nl_d;
  logic              topav_q, topav_d, leftav_q, leftav_d;
  logic [1:0]        xxo_q, xxo_d;
  logic [3:0][9:0]   topsum_q, topsum_d;
  logic [7:0][7:0]   dc_q, dc_d;
  logic [4:0]        wcnt_q, wcnt_d;
  logic [4:0]        fbcount_q, fbcount_d;
  logic [15:0][7:0]  left_q, left_d;
  logic              readyi_q, readyi_d;
  logic              strobeo_q, strobeo_d;
  logic [35:0]       datao_q, datao_d;
  logic [31:0]       baseo_q, baseo_d;
  logic [12:0]       acc_q, acc_d;
  logic              dcpend_q, dcpend_d;
  logic              dcstrobe_q, dcstrobe_d;
  logic [15:0]       dcdata_q, dcdata_d;
  logic              xxc_q, xxc_d, xxinc_q, xxinc_d;

  logic [3:0][9:0]   leftsum;
  logic [7:0][7:0]   dc_calc;
  logic [7:0]        cur_dc;
  logic [3:0][8:0]   res;
  logic [10:0]       rowsum;

  // leftsum index = {component, row half}; left buffer rows are Cb 0..7 then Cr 0..7.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lsum
      assign leftsum[gi] = byte_sum(left_q[gi*4 +: 4]);
    end

    for (gi = 0; gi < 8; gi++) begin : g_dc
      localparam int COMP = gi / 4;
      localparam int BLK  = gi % 4;
      h264_cc_dcpred u_dcpred (
        .t_sum  (topsum_q[COMP*2 + BLK%2]),
        .l_sum  (leftsum[COMP*2 + BLK/2]),
        .top_av (topav_q),
        .left_av(leftav_q),
        .blk    (2'(BLK)),
        .dc     (dc_calc[gi])
      );
    end

    for (gi = 0; gi < 4; gi++) begin : g_res
      assign res[gi] = {1'b0, DATAI[8*gi +: 8]} - {1'b0, cur_dc};
    end
  endgenerate

  // Word k selects DC entry k>>2 = {component, sub-block}.
  assign cur_dc = dc_q[wcnt_q[4:2]];
  assign rowsum = {{2{res[0][8]}}, res[0]} + {{2{res[1][8]}}, res[1]}
                + {{2{res[2][8]}}, res[2]} + {{2{res[3][8]}}, res[3]};

  always_comb begin
    state_d    = state_q;
    ns_d       = ns_q | NEWSLICE;
    nl_d       = nl_q | NEWLINE;
    topav_d    = topav_q;
    leftav_d   = leftav_q;
    xxo_d      = xxo_q;
    topsum_d   = topsum_q;
    dc_d       = dc_q;
    wcnt_d     = wcnt_q;
    fbcount_d  = fbcount_q;
    left_d     = left_q;
    readyi_d   = readyi_q;
    strobeo_d  = 1'b0;
    datao_d    = datao_q;
    baseo_d    = baseo_q;
    acc_d      = acc_q;
    dcpend_d   = 1'b0;
    dcstrobe_d = dcpend_q;
    dcdata_d   = dcpend_q ? {{3{acc_q[12]}}, acc_q} : dcdata_q;
    xxc_d      = 1'b0;
    xxinc_d    = 1'b0;

    if (FBSTROBE && (fbcount_q < FB_FULL)) begin
      left_d[fbcount_q[3:0]] = FEEDBI;
      fbcount_d              = fbcount_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (READYO && (fbcount_q == FB_FULL)) begin
          state_d  = TOPRD;
          xxo_d    = 2'd0;
          xxc_d    = nl_d;
          topav_d  = !ns_d;
          leftav_d = !(ns_d || nl_d);
          ns_d     = 1'b0;
          nl_d     = 1'b0;
        end
      end
      TOPRD: begin
        topsum_d[xxo_q] = byte_sum(TOPI);
        xxo_d           = xxo_q + 2'd1;
        if (xxo_q == 2'd3) state_d = CALC;
      end
      CALC: begin
        dc_d     = dc_calc;
        state_d  = DATA;
        readyi_d = 1'b1;
      end
      DATA: begin
        if (STROBEI) begin
          strobeo_d = 1'b1;
          datao_d   = {res[3], res[2], res[1], res[0]};
          baseo_d   = {4{cur_dc}};
          acc_d     = (wcnt_q[1:0] == 2'd0) ? {{2{rowsum[10]}}, rowsum}
                                            : acc_q + {{2{rowsum[10]}}, rowsum};
          dcpend_d  = (wcnt_q[1:0] == 2'd3);
          wcnt_d    = wcnt_q + 5'd1;
          if (wcnt_q == 5'd0) fbcount_d = 5'd0;
          if (wcnt_q == 5'd31) begin
            state_d  = WAITFB;
            readyi_d = 1'b0;
          end
        end
      end
      WAITFB: begin
        if (fbcount_q == FB_FULL) begin
          xxinc_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK2 or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      ns_q       <= 1'b0;
      nl_q       <= 1'b0;
      topav_q    <= 1'b0;
      leftav_q   <= 1'b0;
      xxo_q      <= 2'd0;
      topsum_q   <= '0;
      dc_q       <= '0;
      wcnt_q     <= 5'd0;
      fbcount_q  <= FB_FULL;
      left_q     <= '0;
      readyi_q   <= 1'b0;
      strobeo_q  <= 1'b0;
      datao_q    <= 36'd0;
      baseo_q    <= 32'd0;
      acc_q      <= 13'd0;
      dcpend_q   <= 1'b0;
      dcstrobe_q <= 1'b0;
      dcdata_q   <= 16'd0;
      xxc_q      <= 1'b0;
      xxinc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ns_q       <= ns_d;
      nl_q       <= nl_d;
      topav_q    <= topav_d;
      leftav_q   <= leftav_d;
      xxo_q      <= xxo_d;
      topsum_q   <= topsum_d;
      dc_q       <= dc_d;
      wcnt_q     <= wcnt_d;
      fbcount_q  <= fbcount_d;
      left_q     <= left_d;
      readyi_q   <= readyi_d;
      strobeo_q  <= strobeo_d;
      datao_q    <= datao_d;
      baseo_q    <= baseo_d;
      acc_q      <= acc_d;
      dcpend_q   <= dcpend_d;
      dcstrobe_q <= dcstrobe_d;
      dcdata_q   <= dcdata_d;
      xxc_q      <= xxc_d;
      xxinc_q    <= xxinc_d;
    end
  end

  assign READYI    = readyi_q;
  assign STROBEO   = strobeo_q;
  assign DATAO     = datao_q;
  assign BASEO     = baseo_q;
  assign DCSTROBEO = dcstrobe_q;
  assign DCDATAO   = dcdata_q;
  assign CMODEO    = CMODE_DC;
  assign XXO       = xxo_q;
  assign XXC       = xxc_q;
  assign XXINC     = xxinc_q;

endmodule

// File: tb/tb_h264_intra8x8_cc.sv
// Directed bench for h264_intra8x8_cc: per-scenario tasks with hand-computed expectations.
module tb_h264_intra8x8_cc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        NEWSLICE, NEWLINE, STROBEI, FBSTROBE, READYO;
  logic [31:0] DATAI, TOPI;
  logic [7:0]  FEEDBI;
  logic        READYI, STROBEO, DCSTROBEO, XXC, XXINC;
  logic [35:0] DATAO;
  logic [31:0] BASEO;
  logic [15:0] DCDATAO;
  logic [1:0]  CMODEO, XXO;

  int checks = 0;
  int failures = 0;

  logic [31:0] top_tab [4];
  assign TOPI = top_tab[XXO];

  logic [35:0] so_data [$];
  logic [31:0] so_base [$];
  logic [15:0] dc_out [$];
  int xxc_cnt = 0;
  int xxinc_cnt = 0;
  int ready_cnt = 0;

  always #5 clk = ~clk;

  h264_intra8x8_cc dut (
    .CLK2(clk), .RSTN(rst_n), .NEWSLICE(NEWSLICE), .NEWLINE(NEWLINE),
    .STROBEI(STROBEI), .DATAI(DATAI), .TOPI(TOPI), .FBSTROBE(FBSTROBE),
    .FEEDBI(FEEDBI), .READYO(READYO), .READYI(READYI), .STROBEO(STROBEO),
    .DATAO(DATAO), .BASEO(BASEO), .DCSTROBEO(DCSTROBEO), .DCDATAO(DCDATAO),
    .CMODEO(CMODEO), .XXO(XXO), .XXC(XXC), .XXINC(XXINC)
  );

  always @(negedge clk) begin
    if (STROBEO) begin
      so_data.push_back(DATAO);
      so_base.push_back(BASEO);
    end
    if (DCSTROBEO) dc_out.push_back(DCDATAO);
    if (XXC) xxc_cnt++;
    if (XXINC) xxinc_cnt++;
    if (READYI) ready_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    so_data.delete();
    so_base.delete();
    dc_out.delete();
    xxc_cnt = 0;
    xxinc_cnt = 0;
    ready_cnt = 0;
  endtask

  task automatic set_flags(input logic ns, input logic nl);
    NEWSLICE = ns;
    NEWLINE  = nl;
    tick();
    NEWSLICE = 1'b0;
    NEWLINE  = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (READYI) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Releases READYO, streams 32 identical words with one stall cycle, then drains.
  task automatic drive_mb(input logic [31:0] w, input string name);
    bit ok;
    READYO = 1'b1;
    wait_ready(ok);
    READYO = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s ready_timeout: READYI=%0b required 1", name, READYI);
      return;
    end
    for (int k = 0; k < 32; k++) begin
      if (k == 10) begin
        STROBEI = 1'b0;
        tick();
      end
      STROBEI = 1'b1;
      DATAI   = w;
      tick();
    end
    STROBEI = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    $display("MB %s: strobes=%0d dcstrobes=%0d xxc=%0d", name, so_data.size(), dc_out.size(), xxc_cnt);
  endtask

  task automatic send_fb(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      FBSTROBE = 1'b1;
      FEEDBI   = v;
      tick();
    end
    FBSTROBE = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  // Compares all 32 words and 8 DC sums against per-sub-block tables (index = comp*4+blk).
  task automatic check_mb(input string name, input logic [8:0] res_tab [8],
                          input logic [7:0] dc_tab [8], input logic [15:0] sum_tab [8]);
    checks++;
    if (so_data.size() != 32 || dc_out.size() != 8) begin
      failures++;
      $display("FAIL %s counts: strobes=%0d dcs=%0d required 32 and 8", name, so_data.size(), dc_out.size());
      return;
    end
    for (int k = 0; k < 32; k++) begin
      logic [35:0] ed;
      logic [31:0] eb;
      ed = {4{res_tab[k/4]}};
      eb = {4{dc_tab[k/4]}};
      checks++;
      if (so_data[k] !== ed) begin
        failures++;
        $display("FAIL %s datao[%0d]: got %h required %h", name, k, so_data[k], ed);
      end
      checks++;
      if (so_base[k] !== eb) begin
        failures++;
        $display("FAIL %s baseo[%0d]: got %h required %h", name, k, so_base[k], eb);
      end
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (dc_out[b] !== sum_tab[b]) begin
        failures++;
        $display("FAIL %s dcdatao[%0d]: got %h required %h", name, b, dc_out[b], sum_tab[b]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({READYI, STROBEO, DATAO, BASEO, DCSTROBEO, DCDATAO, CMODEO, XXO, XXC, XXINC} !== '0) begin
      failures++;
      $display("FAIL %s outputs: readyi=%b strobeo=%b datao=%h baseo=%h dcs=%b dcd=%h xxo=%h xxc=%b xxinc=%b required all 0",
               name, READYI, STROBEO, DATAO, BASEO, DCSTROBEO, DCDATAO, XXO, XXC, XXINC);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_newslice_flat();
    logic [8:0]  r [8];
    logic [7:0]  d [8];
    logic [15:0] s [8];
    for (int i = 0; i < 8; i++) begin r[i] = 9'h000; d[i] = 8'h80; s[i] = 16'h0000; end
    clear_obs();
    top_tab = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    set_flags(1'b1, 1'b0);
    drive_mb(32'h80808080, "slice_flat");
    check_mb("slice_flat", r, d, s);
    send_fb(16, 8'h00);
    checks++;
    if (xxinc_cnt != 1) begin
      failures++;
      $display("FAIL slice_flat xxinc: got %0d pulses required 1", xxinc_cnt);
    end
  endtask

  task automatic test_newslice_data();
    logic [8:0]  r [8];
    logic [7:0]  d [8];
    logic [15:0] s [8];
    clear_obs();
    for (int i = 0; i < 8; i++) begin r[i] = 9'h000; d[i] = 8'h80; s[i] = 16'hFC50; end
    set_flags(1'b1, 1'b0);
    drive_mb(32'h12345678, "slice_data");
    // bytes 78,56,34,12 minus 128 -> -8,-42,-76,-110
    checks++;
    if (so_data.size() > 0 && so_data[0] !== {9'h192, 9'h1B4, 9'h1D6, 9'h1F8}) begin
      failures++;
      $display("FAIL slice_data word0: got %h required %h", so_data[0], {9'h192, 9'h1B4, 9'h1D6, 9'h1F8});
    end
    checks++;
    if (so_base.size() != 32 || so_base[31] !== 32'h80808080) begin
      failures++;
      $display("FAIL slice_data baseo_last: size=%0d required 32 words of 80808080", so_base.size());
    end
    checks++;
    if (dc_out.size() != 8 || dc_out[7] !== 16'hFC50) begin
      failures++;
      $display("FAIL slice_data dcsum: size=%0d required 8 sums of fc50", dc_out.size());
    end
    send_fb(16, 8'h67);
  endtask

  task automatic test_both_avail();
    // Top sums: Cb 150,100  Cr 040,080; left sums all 19c.
    logic [8:0]  r [8] = '{9'h022, 9'h040, 9'h019, 9'h02C, 9'h044, 9'h060, 9'h019, 9'h03C};
    logic [7:0]  d [8] = '{8'h5E, 8'h40, 8'h67, 8'h54, 8'h3C, 8'h20, 8'h67, 8'h44};
    logic [15:0] s [8] = '{16'h0220, 16'h0400, 16'h0190, 16'h02C0, 16'h0440, 16'h0600, 16'h0190, 16'h03C0};
    clear_obs();
    top_tab = '{32'h87654321, 32'h40404040, 32'h10101010, 32'h20202020};
    drive_mb(32'h80808080, "both_avail");
    check_mb("both_avail", r, d, s);
    checks++;
    if (xxc_cnt != 0) begin
      failures++;
      $display("FAIL both_avail xxc: got %0d pulses required 0", xxc_cnt);
    end
    send_fb(16, 8'h10);
  endtask

  task automatic test_newline();
    logic [8:0]  r [8];
    logic [7:0]  d [8];
    logic [15:0] s [8];
    for (int i = 0; i < 8; i++) begin r[i] = 9'h040; d[i] = 8'h40; s[i] = 16'h0400; end
    clear_obs();
    top_tab = '{32'h40404040, 32'h40404040, 32'h40404040, 32'h40404040};
    set_flags(1'b0, 1'b1);
    drive_mb(32'h80808080, "newline");
    check_mb("newline", r, d, s);
    checks++;
    if (xxc_cnt != 1) begin
      failures++;
      $display("FAIL newline xxc: got %0d pulses required 1", xxc_cnt);
    end
  endtask

  task automatic test_fb_withhold_and_reset();
    bit ok;
    clear_obs();
    send_fb(15, 8'h33);
    READYO = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    checks++;
    if (ready_cnt != 0 || xxinc_cnt != 0) begin
      failures++;
      $display("FAIL fb_withhold: readyi_cycles=%0d xxinc=%0d required 0 and 0", ready_cnt, xxinc_cnt);
    end
    send_fb(1, 8'h33);
    checks++;
    if (xxinc_cnt != 1) begin
      failures++;
      $display("FAIL fb_16th xxinc: got %0d pulses required 1", xxinc_cnt);
    end
    wait_ready(ok);
    READYO = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fb_16th next_mb: READYI=%0b required 1", READYI);
    end
    for (int k = 0; k < 5; k++) begin
      STROBEI = 1'b1;
      DATAI   = 32'h11223344;
      tick();
    end
    STROBEI = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_data_reset");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_resume_after_reset();
    logic [8:0]  r [8];
    logic [7:0]  d [8];
    logic [15:0] s [8];
    for (int i = 0; i < 8; i++) begin r[i] = 9'h000; d[i] = 8'h80; s[i] = 16'h0000; end
    clear_obs();
    set_flags(1'b1, 1'b0);
    drive_mb(32'h80808080, "resume");
    check_mb("resume", r, d, s);
  endtask

  initial begin
    rst_n    = 1'b0;
    NEWSLICE = 1'b0;
    NEWLINE  = 1'b0;
    STROBEI  = 1'b0;
    FBSTROBE = 1'b0;
    READYO   = 1'b0;
    DATAI    = 32'd0;
    FEEDBI   = 8'd0;
    top_tab  = '{32'd0, 32'd0, 32'd0, 32'd0};
    test_reset();
    test_newslice_flat();
    test_newslice_data();
    test_both_avail();
    test_newline();
    test_fb_withhold_and_reset();
    test_resume_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
